// File: rtl/apb_arb_master_pkg.sv
// ============================================================================
// apb_pkg : shared FSM encoding and student-record register map | rev 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_mst_st_t;

  localparam logic [7:0] REG_GROUP_NUM    = 8'h00;
  localparam logic [7:0] REG_DATE_DAY     = 8'h04;
  localparam logic [7:0] REG_DATE_MONTH   = 8'h05;
  localparam logic [7:0] REG_DATE_YEAR    = 8'h06;
  localparam logic [7:0] REG_STUDENT_ID   = 8'h07;
  localparam logic [7:0] REG_FIRST_NAME_1 = 8'h08;
  localparam logic [7:0] REG_FIRST_NAME_2 = 8'h09;
  localparam logic [7:0] REG_FIRST_NAME_3 = 8'h0A;
  localparam logic [7:0] REG_FIRST_NAME_4 = 8'h0B;
  localparam logic [7:0] REG_LAST_NAME_1  = 8'h0C;
  localparam logic [7:0] REG_LAST_NAME_2  = 8'h0D;
  localparam logic [7:0] REG_LAST_NAME_3  = 8'h0E;
  localparam logic [7:0] REG_LAST_NAME_4  = 8'h0F;

endpackage

`default_nettype wire

// File: rtl/apb_arb_master_if.sv
// ============================================================================
// apb_arb_master_if : requester command/response and APB bus bundle | rev 1.0
// ============================================================================
`default_nettype none

interface apb_arb_master_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic               pwrite;
  logic               psel;
  logic               penable;
  logic [DW-1:0]      prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
  );
endinterface

`default_nettype wire

// File: rtl/apb_arb_master_rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot round-robin grant searched upward from ptr_i | rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic [PW-1:0]   ptr_nxt_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Modulo-NREQ wrap without a divider; ptr_i is always < NREQ.
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign ptr_nxt_o = (idx_o == PW'(NREQ - 1)) ? '0 : idx_o + PW'(1);

endmodule

`default_nettype wire

// File: rtl/apb_arb_master.sv
// ============================================================================
// apb_arb_master : round-robin shared APB master with ACCESS timeout | rev 1.0
// ============================================================================
`default_nettype none

module apb_arb_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  apb_arb_master_if.master       bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            psel_q, psel_d, penable_q, penable_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx, gnt_ptr_nxt;
  logic [AW-1:0]   req_addr_a  [NREQ];
  logic [DW-1:0]   req_wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_addr_a[i]  = bus.req_addr[i*AW +: AW];
    assign req_wdata_a[i] = bus.req_wdata[i*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx),
    .ptr_nxt_o (gnt_ptr_nxt)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmr_d       = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          own_d     = gnt_idx;
          write_d   = bus.req_write[gnt_idx];
          addr_d    = req_addr_a[gnt_idx];
          wdata_d   = req_wdata_a[gnt_idx];
          ptr_d     = gnt_ptr_nxt;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        tmr_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          rsp_err_d          = bus.pslverr;
          rsp_rdata_d        = write_q ? '0 : bus.prdata;
          rsp_valid_d[own_q] = 1'b1;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          state_d            = S_IDLE;
        end else if (TIMEOUT != 0 && tmr_q == TMAX) begin
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
          rsp_valid_d[own_q] = 1'b1;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          state_d            = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmr_q       <= tmr_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.paddr     = addr_q;
  assign bus.pwdata    = wdata_q;
  assign bus.pwrite    = write_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;

endmodule

`default_nettype wire

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- APB master that shares one APB register slave (student-record register block) between NREQ local requesters.
- Each requester issues single read/write commands over a valid/ready interface.
- Round-robin arbitration selects one requester; the block runs one APB SETUP/ACCESS transfer and returns read data and error status to that requester.
- A per-transfer timeout aborts transfers to a slave that never asserts pready.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 16, ACCESS cycles allowed without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; sole clock.
- preset  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  command valid, one bit per requester.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; command accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester.
- rsp_rdata  out  DW  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pwrite  out  1  APB write flag.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset: on preset (async), all of the following clear to 0 immediately: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timer, rr pointer. State goes to IDLE. All outputs are registered except req_ready, which is 0 outside IDLE.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0.
  - If any req_valid is set, req_ready is the one-hot winner, searched from the rr pointer upward with wrap.
  - At that edge: latch winner index, addr, wdata and write; drive paddr/pwdata/pwrite; set rr pointer = winner+1 mod NREQ; go to SETUP.
  - If no req_valid, stay in IDLE and leave the pointer unchanged.
- SETUP (exactly 1 cycle): psel=1, penable=0. Then go to ACCESS; timer clears.
- ACCESS: psel=1, penable=1.
  - If pready=1: rsp_err <= pslverr; rsp_rdata <= (read ? prdata : 0); rsp_valid[owner] <= 1; psel, penable <= 0; go to IDLE.
  - Else, if TIMEOUT != 0 and timer == TIMEOUT-1: rsp_err <= 1; rsp_rdata <= 0; rsp_valid[owner] <= 1; drop psel/penable; go to IDLE.
  - Else timer increments.
- pslverr and prdata are sampled only when pready=1.
- paddr, pwdata and pwrite are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE.
- rsp_valid is a 1-cycle pulse in the first IDLE cycle after completion. A new grant can be made in that same cycle (back-to-back).
- Minimum transfer: accept (IDLE) + SETUP + 1 ACCESS. The slave's registered pready normally adds 1 ACCESS cycle.
- Boundary conditions:
  - A requester deasserting req_valid before acceptance is legal; no transfer occurs.
  - req_valid held after acceptance is treated as a new command at the next IDLE.
  - Reset mid-transfer aborts silently: no rsp_valid is issued and the bus returns to idle.
- Timer width is $clog2(TIMEOUT+1).

Decomposition:
- Package apb_pkg:
  - enum apb_mst_st_t {ST_IDLE, ST_SETUP, ST_ACCESS}.
  - Slave register offset constants: REG_GROUP_NUM=8'h00, REG_DATE_DAY=8'h04 .. REG_LAST_NAME_4=8'h0F.
- Sub-module rr_arbiter (NREQ): combinational one-hot grant from request vector and pointer, plus pointer update output.

Test Plan:
- Write then read, requester 0:
  - Stimulus: req0 writes 0x17 to 0x00; then req0 reads 0x00.
  - Response: psel rises with penable=0 for 1 cycle, then penable=1 until pready; rsp_valid[0] pulses with rsp_err=0; the read returns rsp_rdata=0x17.
- Round-robin after reset:
  - Stimulus: req0 and req1 valid in the same cycle, 4 commands each.
  - Response: grant order 0,1,0,1,...; no requester is granted twice in a row while the other is waiting.
- Slave error:
  - Stimulus: read 0x40 with slave pslverr=1 alongside pready.
  - Response: rsp_err=1; no hang.
- Timeout:
  - Stimulus: TIMEOUT=16, slave holds pready=0.
  - Response: exactly 16 ACCESS cycles; then rsp_valid pulses with rsp_err=1, rsp_rdata=0, and psel drops.
- Wait states:
  - Stimulus: pready delayed 3 cycles on a write.
  - Response: paddr, pwdata and pwrite are unchanged for every cycle of psel=1.
- Reset mid-transfer:
  - Stimulus: preset asserted during ACCESS.
  - Response: psel=penable=0 without waiting for a clock edge; no rsp_valid; the first grant after reset goes to requester 0.
